// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, WIDTH steps per operation.
// Optional feature macro: MDU_SIGNED_EN (two's-complement operands when defined;
// otherwise signed_op is ignored and every operation is unsigned).
module mul_div_unit #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic             signed_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] overflow,
    output logic             div_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               op_r;
    logic               sgn_r;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   md;
    logic [CNT_W-1:0]   cnt;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifndef MDU_SIGNED_EN
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
`endif

    // Pipeline hold: while busy, or on the cycle a request is accepted.
    assign stall = busy | (start & (state == S_IDLE) & ~flush);

    // Operand magnitudes, one datapath step, and final sign correction.
    always_comb begin
        a_neg     = sgn_r & a_r[WIDTH-1];
        b_neg     = sgn_r & b_r[WIDTH-1];
        mag_a     = a_neg ? (~a_r + WIDTH'(1)) : a_r;
        mag_b     = b_neg ? (~b_r + WIDTH'(1)) : b_r;
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
        div_trial = {hi, lo[WIDTH-1]};
        div_diff  = div_trial - {1'b0, md};
        prod      = {hi, lo};
        prod_fix  = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
        quo_fix   = neg_q ? (~lo + WIDTH'(1)) : lo;
        rem_fix   = neg_r ? (~hi + WIDTH'(1)) : hi;
    end

    // Control FSM with registered busy/done and the iterating datapath.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
            overflow <= '0;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= 1'b0;
            sgn_r    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            md       <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= op;
`ifdef MDU_SIGNED_EN
                        sgn_r <= signed_op;
`else
                        sgn_r <= 1'b0;
`endif
                        busy  <= 1'b1;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (op_r && (b_r == '0)) begin
                        result   <= '1;
                        overflow <= a_r;
                        div_zero <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        // Multiply: md = multiplicand, lo = multiplier.
                        // Divide:   md = divisor, lo = dividend shifting into quotient.
                        md    <= op_r ? mag_b : mag_a;
                        lo    <= op_r ? mag_a : mag_b;
                        hi    <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (!op_r) begin
                            hi <= mul_sum[WIDTH:1];
                            lo <= {mul_sum[0], lo[WIDTH-1:1]};
                        end else if (!div_diff[WIDTH]) begin
                            hi <= div_diff[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b1};
                        end else begin
                            hi <= div_trial[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (!op_r) begin
                            {overflow, result} <= prod_fix;
                        end else begin
                            result   <= quo_fix;
                            overflow <= rem_fix;
                        end
                        div_zero <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
